// File: rtl/serial_gate_pkg.sv
// serial_gate_pkg: truth-table op encodings for the serial gate deserializer, indexed by {a,b}
package serial_gate_pkg;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1110;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NAND = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b0001;
endpackage

// File: rtl/mux.sv
// mux: 2:1 single-bit multiplexer (sel, d0, d1 -> y)
module mux (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/serial_gate_deserializer_lut2.sv
// lut2_using_mux: 2-input truth-table gate y = op[{a,b}] from three mux instances (op, a, b -> y)
module lut2_using_mux (
  input  logic [3:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);
  logic lo, hi;
  mux u_lo (.sel(b), .d0(op[0]), .d1(op[1]), .y(lo));
  mux u_hi (.sel(b), .d0(op[2]), .d1(op[3]), .y(hi));
  mux u_a  (.sel(a), .d0(lo),    .d1(hi),    .y(y));
endmodule

// File: rtl/serial_gate_deserializer.sv
// serial_gate_deserializer: applies op[{a,b}] per accepted bit pair and packs results LSB-first into WIDTH-bit words on a valid/ready output
module serial_gate_deserializer
  import serial_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic             a,
  input  logic             b,
  input  logic [3:0]       op,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data,
  output logic             down_any
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] word;
  logic [3:0]       op_sel;
  logic             r, first, last, beat;
  assign first    = cnt == '0;
  assign last     = cnt == CW'(WIDTH - 1);
  assign op_sel   = first ? op : op_q;
  assign up_ready = !rst && !(last && down_valid && !down_ready);
  assign beat     = up_valid && up_ready;
  assign word     = {r, acc[WIDTH-2:0]};
  lut2_using_mux u_lut (.op(op_sel), .a(a), .b(b), .y(r));
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      op_q       <= '0;
      acc        <= '0;
      down_valid <= 1'b0;
      down_data  <= '0;
      down_any   <= 1'b0;
    end else begin
      if (beat) begin
        acc[cnt] <= r;
        cnt      <= last ? '0 : cnt + 1'b1;
        if (first) op_q <= op;
      end
      if (beat && last) begin
        down_data  <= word;
        down_any   <= |word;
        down_valid <= 1'b1;
      end else if (down_valid && down_ready) begin
        down_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_gate_deserializer.sv
// tb_serial_gate_deserializer: scoreboard bench for serial_gate_deserializer and lut2_using_mux
module tb_serial_gate_deserializer;
  import serial_gate_pkg::*;
  logic       clk = 0, rst = 1;
  logic       up_valid = 0, up_ready, a = 0, b = 0;
  logic [3:0] op = 0;
  logic       down_valid, down_ready = 1, down_any;
  logic [7:0] down_data;
  logic [3:0] lop;
  logic       la, lb, ly;
  logic [8:0] sb[$];
  int checks = 0, errors = 0;
  serial_gate_deserializer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready),
    .a(a), .b(b), .op(op), .down_valid(down_valid), .down_ready(down_ready),
    .down_data(down_data), .down_any(down_any)
  );
  lut2_using_mux u_lut (.op(lop), .a(la), .b(lb), .y(ly));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && down_valid && down_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL word: unexpected word %0h", down_data);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        if ({down_data, down_any} !== e) begin
          errors++;
          $display("FAIL word: got data %0h any %0b expected data %0h any %0b", down_data, down_any, e[8:1], e[0]);
        end
      end
    end
  end
  task automatic beat(input logic ai, input logic bi, input logic [3:0] o);
    int n;
    up_valid = 1; a = ai; b = bi; op = o; n = 0;
    @(negedge clk);
    while (!up_ready && n < 50) begin n++; @(negedge clk); end
    if (!up_ready) begin errors++; checks++; $display("FAIL beat_timeout: up_ready stuck at 0 expected 1"); end
    @(posedge clk); #1;
  endtask
  task automatic send_word(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] o1,
                           input logic [3:0] o2, input int sw, input logic [7:0] exp);
    sb.push_back({exp, |exp});
    for (int i = 0; i < 8; i++) beat(av[i], bv[i], (i < sw) ? o1 : o2);
    up_valid = 0;
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("reset_up_ready", up_ready, 0);
    chk("reset_valid", down_valid, 0);
    chk("reset_data", down_data, 0);
    chk("reset_any", down_any, 0);
    @(posedge clk); #1 rst = 0;
    send_word(8'hA5, 8'h0F, OP_OR, OP_OR, 8, 8'hAF);
    chk("or_valid_latency", down_valid, 1);
    chk("or_data", down_data, 8'hAF);
    chk("or_any", down_any, 1);
    send_word(8'hF0, 8'h0F, OP_AND, OP_AND, 8, 8'h00);
    chk("and_any", down_any, 0);
    send_word(8'h3C, 8'hFF, OP_XOR, OP_XOR, 8, 8'hC3);
    chk("xor_data", down_data, 8'hC3);
    @(posedge clk); #1;
    down_ready = 0;
    sb.push_back({8'h36, 1'b1});
    sb.push_back({8'hC1, 1'b1});
    for (int i = 0; i < 8; i++) beat(((8'h12 >> i) & 1) != 0, ((8'h34 >> i) & 1) != 0, OP_OR);
    for (int i = 0; i < 7; i++) beat(((8'h81 >> i) & 1) != 0, ((8'h40 >> i) & 1) != 0, OP_OR);
    up_valid = 1; a = 1; b = 0; op = OP_OR;
    @(negedge clk);
    chk("bp_stall_up_ready", up_ready, 0);
    chk("bp_hold_valid", down_valid, 1);
    chk("bp_hold_data", down_data, 8'h36);
    @(posedge clk); #1 down_ready = 1;
    @(negedge clk);
    chk("bp_release_up_ready", up_ready, 1);
    @(posedge clk); #1;
    up_valid = 0; down_ready = 0;
    chk("bp_no_bubble_valid", down_valid, 1);
    chk("bp_second_data", down_data, 8'hC1);
    @(posedge clk); #1 down_ready = 1;
    @(posedge clk); #1;
    send_word(8'h5A, 8'h0C, OP_OR, OP_AND, 3, 8'h5E);
    chk("opchg_data", down_data, 8'h5E);
    for (int i = 0; i < 5; i++) beat(1, 1, OP_XOR);
    up_valid = 0; rst = 1;
    @(negedge clk);
    chk("rst_up_ready", up_ready, 0);
    @(posedge clk); #1;
    chk("rst_valid", down_valid, 0);
    chk("rst_data", down_data, 0);
    chk("rst_any", down_any, 0);
    rst = 0;
    send_word(8'h00, 8'h0F, OP_NOR, OP_NOR, 8, 8'hF0);
    chk("fresh_data", down_data, 8'hF0);
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(posedge clk); n++; end
    chk("scoreboard_empty", sb.size(), 0);
    for (int o = 0; o < 16; o++)
      for (int ab = 0; ab < 4; ab++) begin
        lop = 4'(o); la = ab[1]; lb = ab[0];
        #1 chk("lut", ly, (o >> ab) & 1);
      end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
